fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: issues one imem read per PC, holds the word until the next stage takes it.
// Latency: if_valid one cycle after imem_ack. Backpressure: if_ready=0 holds HOLD; ack timeout or misaligned PC faults sticky.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    localparam int            WW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WW-1:0] W_LIMIT  = WW'(ACK_TIMEOUT - 1);
    localparam logic [WW-1:0] W_ONE    = WW'(1);

    logic [1:0]    r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [31:0]   r_count;
    logic [WW-1:0] r_wait;
    // Set on the first edge after reset release so no request is seen while or right as reset drops.
    logic          r_active;

    logic w_req;

    assign w_req = (r_state == FETCH) && r_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_instr  <= 32'h0;
            r_count  <= 32'h0;
            r_wait   <= '0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                FETCH: begin
                    if (w_req) begin
                        // An ack on the final allowed cycle still wins over the timeout.
                        if (imem_ack) begin
                            r_instr <= imem_rdata;
                            r_wait  <= '0;
                            r_state <= HOLD;
                        end else if (r_wait == W_LIMIT) begin
                            r_state <= FAULT;
                        end else begin
                            r_wait <= r_wait + W_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        r_pc    <= pc_next;
                        r_count <= r_count + 32'd1;
                        r_state <= (pc_next[1:0] != 2'b00) ? FAULT : FETCH;
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= FAULT;
                end
            endcase
        end
    end

    assign imem_req       = w_req;
    assign imem_addr      = r_pc;
    assign if_pc          = r_pc;
    assign if_instruction = r_instr;
    assign if_valid       = (r_state == HOLD);
    assign fault          = (r_state == FAULT);
    assign fetch_count    = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main flow plus hand sequences for timeout and reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_ready;
    logic        fault;
    logic [31:0] fetch_count;

    int checks;
    int failures;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc_next        (pc_next),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc_next;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic r, logic [31:0] pn, logic a, logic [31:0] rd, logic rdy,
                                logic er, logic [31:0] ep, logic ev, logic [31:0] ei,
                                logic ef, logic [31:0] ec);
        vec_t v;
        v.rst = r; v.pc_next = pn; v.ack = a; v.rdata = rd; v.rdy = rdy;
        v.e_req = er; v.e_pc = ep; v.e_valid = ev; v.e_instr = ei; v.e_fault = ef; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'h0);
        chk({tag, "_pc"},    if_pc, 32'h0);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_instr"}, if_instruction, 32'h0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_cnt"},   fetch_count, 32'h0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        pc_next = 32'h0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        if_ready = 1'b0;

        // rst, pc_next, ack, rdata, rdy | req, pc, valid, instr, fault, count  (state after the edge)
        tbl[0]  = mk(1, 32'h0,  0, 32'h0,         0,  1, 32'h0,  0, 32'h0,         0, 32'd0);
        tbl[1]  = mk(1, 32'h0,  0, 32'h0,         0,  1, 32'h0,  0, 32'h0,         0, 32'd0);
        tbl[2]  = mk(1, 32'h0,  1, 32'h00A0_0000, 0,  0, 32'h0,  1, 32'h00A0_0000, 0, 32'd0);
        tbl[3]  = mk(1, 32'h4,  0, 32'h0,         1,  1, 32'h4,  0, 32'h00A0_0000, 0, 32'd1);
        tbl[4]  = mk(1, 32'h0,  1, 32'h1234_5678, 0,  0, 32'h4,  1, 32'h1234_5678, 0, 32'd1);
        tbl[5]  = mk(1, 32'h8,  0, 32'h0,         0,  0, 32'h4,  1, 32'h1234_5678, 0, 32'd1);
        tbl[6]  = mk(1, 32'h8,  1, 32'hDEAD_BEEF, 0,  0, 32'h4,  1, 32'h1234_5678, 0, 32'd1);
        tbl[7]  = mk(1, 32'h8,  0, 32'h0,         0,  0, 32'h4,  1, 32'h1234_5678, 0, 32'd1);
        tbl[8]  = mk(1, 32'h8,  0, 32'h0,         0,  0, 32'h4,  1, 32'h1234_5678, 0, 32'd1);
        tbl[9]  = mk(1, 32'h8,  0, 32'h0,         0,  0, 32'h4,  1, 32'h1234_5678, 0, 32'd1);
        tbl[10] = mk(1, 32'h8,  0, 32'h0,         1,  1, 32'h8,  0, 32'h1234_5678, 0, 32'd2);
        tbl[11] = mk(1, 32'h0,  0, 32'h0,         0,  1, 32'h8,  0, 32'h1234_5678, 0, 32'd2);
        tbl[12] = mk(1, 32'h0,  1, 32'hCAFE_F00D, 0,  0, 32'h8,  1, 32'hCAFE_F00D, 0, 32'd2);
        tbl[13] = mk(1, 32'h16, 0, 32'h0,         1,  0, 32'h16, 0, 32'hCAFE_F00D, 1, 32'd3);
        tbl[14] = mk(1, 32'h0,  1, 32'h1111_1111, 1,  0, 32'h16, 0, 32'hCAFE_F00D, 1, 32'd3);
        tbl[15] = mk(0, 32'h0,  0, 32'h0,         0,  0, 32'h0,  0, 32'h0,         0, 32'd0);

        #2 rst = 1'b0;
        step();
        step();
        chk_reset_vals("reset");

        for (int i = 0; i < 16; i++) begin
            rst        = tbl[i].rst;
            pc_next    = tbl[i].pc_next;
            imem_ack   = tbl[i].ack;
            imem_rdata = tbl[i].rdata;
            if_ready   = tbl[i].rdy;
            step();
            chk($sformatf("row%0d_req", i),   {31'd0, imem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("row%0d_addr", i),  imem_addr, tbl[i].e_pc);
            chk($sformatf("row%0d_pc", i),    if_pc, tbl[i].e_pc);
            chk($sformatf("row%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("row%0d_instr", i), if_instruction, tbl[i].e_instr);
            chk($sformatf("row%0d_fault", i), {31'd0, fault}, {31'd0, tbl[i].e_fault});
            chk($sformatf("row%0d_cnt", i),   fetch_count, tbl[i].e_cnt);
        end

        // Timeout: 16 request cycles with no ack, then fault.
        imem_ack = 1'b0;
        if_ready = 1'b0;
        pc_next  = 32'h0;
        rst = 1'b1;
        chk("to_req_before_edge", {31'd0, imem_req}, 32'd0);
        begin
            int req_cycles;
            req_cycles = 0;
            for (int c = 0; c < 16; c++) begin
                step();
                if (imem_req) req_cycles++;
            end
            chk("to_req_cycles", req_cycles, 32'd16);
        end
        chk("to_fault_at16", {31'd0, fault}, 32'd0);
        step();
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_req_off", {31'd0, imem_req}, 32'd0);
        chk("to_valid_off", {31'd0, if_valid}, 32'd0);

        // Ack arriving in the 16th request cycle avoids the fault.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        repeat (15) step();
        chk("lastack_req16", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hA5A5_0001;
        step();
        imem_ack   = 1'b0;
        chk("lastack_fault", {31'd0, fault}, 32'd0);
        chk("lastack_valid", {31'd0, if_valid}, 32'd1);
        chk("lastack_instr", if_instruction, 32'hA5A5_0001);

        // Reset while waiting for ack at address 8, then a late ack.
        if_ready = 1'b1;
        pc_next  = 32'h8;
        step();
        if_ready = 1'b0;
        chk("mid_addr8", imem_addr, 32'h8);
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        chk("mid_cnt", fetch_count, 32'd1);
        step();
        #2 rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        step();
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0077;
        #1;
        chk("rel_req_low", {31'd0, imem_req}, 32'd0);
        step();
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);
        step();
        imem_ack = 1'b0;
        chk("late_valid", {31'd0, if_valid}, 32'd1);
        chk("late_pc", if_pc, 32'h0);
        chk("late_instr", if_instruction, 32'h0000_0077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
